// File: rtl/xpb_table_gen.sv
// xpb_table_gen: builds the table entry[i] = i*B mod N for i = 0..2^DIGIT_BITS-1,
// where B = 2^k mod N. B is found by k modular doublings, and the entries by
// repeated modular addition of B. Every step uses one conditional subtract at
// WIDTH+1 bits.
//
// Optional feature: define XPB_GEN_STALL_EN to add the wr_ready handshake.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - one-cycle build request, ignored unless idle
//   modulus  - N (> 1), latched on start
//   shift    - k, latched on start
//   wr_ready - (XPB_GEN_STALL_EN only) table sink accepts the current write
//   busy     - run in progress (BASE / EMIT)
//   done     - one-cycle completion pulse
//   wr_en    - table write strobe
//   wr_addr  - table index i
//   wr_data  - table entry i*B mod N
module xpb_table_gen #(
    parameter int unsigned WIDTH      = 1024,
    parameter int unsigned DIGIT_BITS = 5,
    parameter int unsigned SHIFT_BITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [SHIFT_BITS-1:0] shift,
`ifdef XPB_GEN_STALL_EN
    input  logic                  wr_ready,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    typedef enum logic [1:0] {StIdle, StBase, StEmit, StFin} state_t;

    localparam logic [DIGIT_BITS-1:0] LastIdx = '1;

    state_t                state;
    logic [WIDTH-1:0]      n_q;
    logic [SHIFT_BITS-1:0] cnt;
    logic [WIDTH-1:0]      base;
    logic [WIDTH-1:0]      acc;
    logic [DIGIT_BITS-1:0] idx;
    logic                  busy_q;
    logic                  done_q;
    logic                  wr_en_q;
    logic                  accept;

    logic [WIDTH:0] dbl_t;
    logic [WIDTH:0] dbl_r;
    logic [WIDTH:0] sum_t;
    logic [WIDTH:0] sum_r;

`ifdef XPB_GEN_STALL_EN
    assign accept = wr_ready;
`else
    assign accept = 1'b1;
`endif

    // Operands are always < N, so a single conditional subtract reduces fully.
    always_comb begin
        dbl_t = {base, 1'b0};
        dbl_r = (dbl_t >= {1'b0, n_q}) ? dbl_t - {1'b0, n_q} : dbl_t;
        sum_t = {1'b0, acc} + {1'b0, base};
        sum_r = (sum_t >= {1'b0, n_q}) ? sum_t - {1'b0, n_q} : sum_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            n_q     <= '0;
            cnt     <= '0;
            base    <= '0;
            acc     <= '0;
            idx     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        n_q    <= modulus;
                        cnt    <= shift;
                        base   <= WIDTH'(1);
                        acc    <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        if (shift != '0) begin
                            state <= StBase;
                        end else begin
                            state   <= StEmit;
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                StBase: begin
                    base <= dbl_r[WIDTH-1:0];
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHIFT_BITS'(1)) begin
                        state   <= StEmit;
                        wr_en_q <= 1'b1;
                    end
                end
                StEmit: begin
                    // wr_addr/wr_data are idx/acc directly, so they hold while stalled.
                    if (accept) begin
                        if (idx == LastIdx) begin
                            state   <= StFin;
                            wr_en_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            acc     <= '0;
                            idx     <= '0;
                        end else begin
                            acc <= sum_r[WIDTH-1:0];
                            idx <= idx + 1'b1;
                        end
                    end
                end
                StFin: begin
                    done_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = idx;
    assign wr_data = acc;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen. Stimulus pushes the expected table
// (computed as i * (2^k mod N) mod N with wide arithmetic) and the expected
// start-to-done latency; a negedge monitor pops and compares on every
// accepted write and on every done pulse.
module tb_xpb_table_gen;

    localparam int W       = 1024;
    localparam int D       = 5;
    localparam int S       = 11;
    localparam int ENTRIES = 1 << D;
    localparam int BIG     = W + (1 << S) + 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] modulus;
    logic [S-1:0] shift;
    logic         wr_ready;
    logic         busy;
    logic         done;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [D-1:0] exp_addr_q[$];
    logic [W-1:0] exp_data_q[$];
    int           exp_lat_q[$];
    int           t0_q[$];
    int           run_writes = 0;
    int           stalls     = 0;
    bit           hold_prev  = 0;
    logic [D-1:0] prev_addr;
    logic [W-1:0] prev_data;

    xpb_table_gen #(
        .WIDTH     (W),
        .DIGIT_BITS(D),
        .SHIFT_BITS(S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .modulus (modulus),
        .shift   (shift),
`ifdef XPB_GEN_STALL_EN
        .wr_ready(wr_ready),
`endif
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pow2_mod(input logic [W-1:0] n, input int k);
        logic [BIG-1:0] p;
        logic [BIG-1:0] r;
        p    = '0;
        p[k] = 1'b1;
        r    = p % n;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] entry(input logic [W-1:0] n, input logic [W-1:0] b,
                                           input int i);
        logic [W+7:0] prod;
        logic [W+7:0] r;
        prod = (W + 8)'(b) * (W + 8)'(i);
        r    = prod % n;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int j = 0; j < W / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Write sink readiness: always ready unless the stall handshake exists.
`ifdef XPB_GEN_STALL_EN
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = ($urandom_range(0, 3) != 0);
        end
    end
`else
    initial wr_ready = 1'b1;
`endif

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (hold_prev) begin
                    check("stall hold wr_en", W'(wr_en), W'(1));
                    check("stall hold wr_addr", W'(wr_addr), W'(prev_addr));
                    check("stall hold wr_data", wr_data, prev_data);
                end
                if (wr_en && wr_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected write", W'(1), W'(0));
                    end else begin
                        check("wr_addr", W'(wr_addr), W'(exp_addr_q.pop_front()));
                        check("wr_data", wr_data, exp_data_q.pop_front());
                        run_writes++;
                    end
                end
                if (wr_en && !wr_ready) stalls++;
                hold_prev = wr_en && !wr_ready;
                prev_addr = wr_addr;
                prev_data = wr_data;
                if (done) begin
                    check("busy low at done", W'(busy), W'(0));
                    if (exp_lat_q.size() == 0) begin
                        check("unexpected done", W'(1), W'(0));
                    end else begin
                        check("latency", W'(cyc - t0_q.pop_front() - stalls),
                              W'(exp_lat_q.pop_front()));
                        check("writes per run", W'(run_writes), W'(ENTRIES));
                    end
                    run_writes = 0;
                    stalls     = 0;
                end
            end
        end
    end

    task automatic flush();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_lat_q.delete();
        t0_q.delete();
        run_writes = 0;
        stalls     = 0;
        hold_prev  = 0;
    endtask

    // Called aligned to posedge+1 with the DUT idle.
    task automatic start_run(input logic [W-1:0] n, input int k, input bit disturb);
        logic [W-1:0] b;
        b = pow2_mod(n, k);
        for (int i = 0; i < ENTRIES; i++) begin
            exp_addr_q.push_back(D'(i));
            exp_data_q.push_back(entry(n, b, i));
        end
        exp_lat_q.push_back(k + ENTRIES + 1);
        t0_q.push_back(cyc);
        modulus = n;
        shift   = S'(k);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        modulus = rand_wide();
        shift   = S'($urandom);
        if (disturb) begin
            repeat (9) begin
                @(posedge clk);
                #1;
            end
            modulus = rand_wide() | W'(2);
            shift   = S'($urandom_range(0, 20));
            start   = 1'b1;
            @(posedge clk);
            #1;
            start   = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done timeout", W'(0), W'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [W-1:0] n, input int k, input bit disturb);
        start_run(n, k, disturb);
        wait_done();
    endtask

    initial begin
        logic [W-1:0] n;
        bit           seen;
        rst     = 1'b1;
        start   = 1'b0;
        modulus = '0;
        shift   = '0;
        @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset wr_en", W'(wr_en), W'(0));
        check("reset wr_addr", W'(wr_addr), W'(0));
        check("reset wr_data", wr_data, W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        run(W'(13), 0, 0);
        run(W'(13), 4, 0);
        n = '1;
        run(n, 1023, 0);
        run(rand_wide() | W'(2), 4, 1);
        run(W'(13), 4, 1);

        // Reset in the middle of EMIT at i=7
        start_run(rand_wide() >> 500 | W'(3), 3, 0);
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            if (wr_en && wr_addr == D'(7)) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) check("reach i=7 timeout", W'(0), W'(1));
        rst = 1'b1;
        check("writes before reset", W'(run_writes), W'(7));
        flush();
        @(negedge clk);
        check("mid-run reset busy", W'(busy), W'(0));
        check("mid-run reset done", W'(done), W'(0));
        check("mid-run reset wr_en", W'(wr_en), W'(0));
        check("mid-run reset wr_addr", W'(wr_addr), W'(0));
        check("mid-run reset wr_data", wr_data, W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        run(W'(13), 4, 0);

        for (int r = 0; r < 20; r++) begin
            n = rand_wide() >> $urandom_range(0, W - 2);
            if (n < 2) n = W'(2) + W'($urandom_range(0, 100));
            run(n, $urandom_range(0, 64), r[2]);
        end

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("leftover writes", W'(exp_addr_q.size()), W'(0));
        check("leftover dones", W'(exp_lat_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1024: operand and table-entry width in bits.
REQ-002 The block SHALL have parameter DIGIT_BITS, default 5: digit width; the table has 2^DIGIT_BITS entries.
REQ-003 The block SHALL have parameter SHIFT_BITS, default 11: width of the shift input.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to build a table.
REQ-007 The block SHALL have port modulus, input, WIDTH bits: N; the caller guarantees N > 1.
REQ-008 The block SHALL have port shift, input, SHIFT_BITS bits: k; the table base is B = 2^k mod N.
REQ-009 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the table is complete.
REQ-011 The block SHALL have port wr_en, output, 1 bit: table write strobe.
REQ-012 The block SHALL have port wr_addr, output, DIGIT_BITS bits: table index i.
REQ-013 The block SHALL have port wr_data, output, WIDTH bits: entry value i*B mod N.

Function
REQ-014 The FSM SHALL have four states, IDLE, BASE, EMIT and FIN, all outputs registered.
REQ-015 In IDLE, start=1 SHALL latch modulus and shift, set base=1 and acc=0, and move to BASE (k>0) or EMIT (k=0).
REQ-016 In BASE, each cycle SHALL compute t=2*base at WIDTH+1 bits, set base = t-N if t>=N else t, and leave after exactly k cycles.
REQ-017 In EMIT, each accepted cycle SHALL drive wr_en=1, wr_addr=i and wr_data=acc, then set acc=(acc+base) mod N using one conditional subtract at WIDTH+1 bits, and increment i.
REQ-018 EMIT SHALL write i=0..2^DIGIT_BITS-1 in ascending order, exactly once each; entry 0 SHALL be 0.
REQ-019 After the write of the last index, the block SHALL enter FIN, pulse done=1 for one cycle with busy=0, then return to IDLE.
REQ-020 Latency SHALL be k + 2^DIGIT_BITS + 1 cycles from start to done with no stalls.
REQ-021 start while not in IDLE SHALL be ignored, with no effect on the latched operands or the sequence.
REQ-022 modulus and shift changes after acceptance SHALL NOT affect the table in progress.
REQ-023 The i counter SHALL NOT wrap within one run; the index width is exactly DIGIT_BITS.

Reset
REQ-024 rst=1 SHALL force IDLE immediately, with busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, and base, acc and i cleared.
REQ-025 Reset mid-BASE or mid-EMIT SHALL abort the run with no further writes and no done pulse; the next start SHALL begin a clean run.

Configuration
REQ-026 Macro XPB_GEN_STALL_EN defined SHALL add input wr_ready (1 bit); in EMIT, wr_en, wr_addr and wr_data SHALL hold stable until wr_ready=1, and acc and i SHALL advance only on wr_en&&wr_ready.
REQ-027 With XPB_GEN_STALL_EN undefined there SHALL be no wr_ready port, and every wr_en cycle SHALL count as accepted.

Verification
REQ-028 N=13, k=0, start -> 32 writes with entry[i] = i mod 13 (entry[31]=5); done at cycle 33.
REQ-029 N=13, k=4 -> B=3; entry[5]=2, entry[31]=2; done at cycle 4+32+1=37.
REQ-030 N=2^1024-1, k=1023 -> entry[1]=2^1023, entry[2]=1, entry[3]=2^1023+1.
REQ-031 start pulsed on cycle 10 of a run with different modulus -> table identical to an undisturbed run; single done.
REQ-032 rst asserted during EMIT at i=7 -> outputs zero next edge, no writes i>=7, no done; a subsequent run is correct.
REQ-033 With XPB_GEN_STALL_EN: wr_ready low 3 cycles at i=4 -> wr_addr=4 and wr_data held, no skipped or duplicate index, done delayed by 3 cycles.
